// File: rtl/down_counter_timer_pkg.sv
// Shared types and default sizing for the loadable down-counter timer.
package down_counter_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dct_state_t;

  localparam int DCT_WIDTH_DEF    = 4;
  localparam int DCT_PRESCALE_DEF = 1;

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by PRESCALE; tick is high on the cycle the phase wraps.
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] phase_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= '0;
    end else if (clear) begin
      phase_q <= '0;
    end else if (enable) begin
      phase_q <= (phase_q == LAST) ? '0 : phase_q + CW'(1);
    end
  end

  assign tick = enable && (phase_q == LAST);

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter with one-shot terminal-count pulse and held done level.
// Optional feature macro: DOWN_COUNTER_TIMER_RELOAD_EN (auto_reload port + reload register).
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH    = DCT_WIDTH_DEF,
  parameter int PRESCALE = DCT_PRESCALE_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  input  logic             stop,
`ifdef DOWN_COUNTER_TIMER_RELOAD_EN
  input  logic             auto_reload,
`endif
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  dct_state_t       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             tick;
  logic             reload_on;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable && (state_q == RUN)),
    .clear   (load || stop),
    .tick    (tick)
  );

`ifdef DOWN_COUNTER_TIMER_RELOAD_EN
  logic [WIDTH-1:0] reload_q;

  // Zero is never captured: a zero load terminates instead of running.
  always_ff @(posedge clk) begin
    if (load && (load_val != '0)) begin
      reload_q <= load_val;
    end
  end

  assign reload_on = auto_reload;
`else
  assign reload_on = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    if (stop) begin
      state_d = IDLE;
      count_d = '0;
    end else if (load) begin
      if (load_val != '0) begin
        state_d = RUN;
        count_d = load_val;
      end else begin
        state_d = DONE;
        count_d = '0;
        tc_d    = 1'b1;
      end
    end else if ((state_q == RUN) && tick) begin
      if (count_q > WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
      end else if (count_q == WIDTH'(1)) begin
        count_d = '0;
        tc_d    = 1'b1;
        if (!reload_on) begin
          state_d = DONE;
        end
      end else begin
        // Only reachable in reload mode: the zero cycle is shown once, then refilled.
        if (reload_on) begin
`ifdef DOWN_COUNTER_TIMER_RELOAD_EN
          count_d = reload_q;
`endif
        end else begin
          state_d = DONE;
        end
      end
    end
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  assign count = count_q;
  assign tc    = tc_q;

endmodule
